// File: rtl/fdtd_pkg.sv
// Shared types and fixed-point constants for the 1-D FDTD field update stage.
package fdtd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } fdtd_upd_state_e;

  localparam logic FDTD_MODE_HY = 1'b0;
  localparam logic FDTD_MODE_EZ = 1'b1;

  localparam int          FDTD_FRAC_BITS = 16;
  localparam logic [31:0] FDTD_SAT_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] FDTD_SAT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/fdtd_fxp_mac.sv
// Two-stage fixed-point multiply-add: S2 registers both products, S3 sums,
// shifts right by FRAC_BITS (floor) and saturates into the output register.
module fdtd_fxp_mac
  import fdtd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = FDTD_FRAC_BITS,
  parameter int TAG_WIDTH  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] c_self,
  input  logic [DATA_WIDTH-1:0] c_curl,
  input  logic [DATA_WIDTH-1:0] self_val,
  input  logic [DATA_WIDTH:0]   curl_val,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  s2_valid,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int PW = 2*DATA_WIDTH + 1;
  localparam int SW = 2*DATA_WIDTH + 2;
  localparam int HW = SW - DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]   prod_self_s, prod_curl_s;
  logic signed [PW-1:0]   p_self_r, p_curl_r;
  logic [TAG_WIDTH-1:0]   s2_tag_r;
  logic                   s2_valid_r;
  logic signed [SW-1:0]   sum_s, shift_s;
  logic [HW-1:0]          hi_s;
  logic [DATA_WIDTH-1:0]  sat_s;

  assign prod_self_s = PW'($signed(c_self)) * PW'($signed(self_val));
  assign prod_curl_s = PW'($signed(c_curl)) * PW'($signed(curl_val));
  assign sum_s       = SW'(p_self_r) + SW'(p_curl_r);
  assign shift_s     = sum_s >>> FRAC_BITS;
  assign hi_s        = shift_s[SW-1:DATA_WIDTH-1];
  assign s2_valid    = s2_valid_r;

  // The result fits when every bit above the output sign bit repeats it.
  always_comb begin
    sat_s = shift_s[DATA_WIDTH-1:0];
    if ((hi_s == {HW{1'b0}}) || (hi_s == {HW{1'b1}})) begin
      sat_s = shift_s[DATA_WIDTH-1:0];
    end else if (hi_s[HW-1]) begin
      sat_s = SAT_MIN;
    end else begin
      sat_s = SAT_MAX;
    end
  end

  // S2 product register, frozen while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      p_self_r   <= {PW{1'b0}};
      p_curl_r   <= {PW{1'b0}};
      s2_tag_r   <= {TAG_WIDTH{1'b0}};
    end else if (en) begin
      s2_valid_r <= in_valid;
      p_self_r   <= prod_self_s;
      p_curl_r   <= prod_curl_s;
      s2_tag_r   <= in_tag;
    end
  end

  // S3 output register; data and tag hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
      out_tag   <= {TAG_WIDTH{1'b0}};
    end else if (en) begin
      out_valid <= s2_valid_r;
      out_data  <= sat_s;
      out_tag   <= s2_tag_r;
    end
  end

endmodule

// File: rtl/fdtd_field_update.sv
// Streaming FDTD field update: out[i] = c_self*self[i] + c_curl*curl[i],
// forward curl for Hy and backward curl for Ez, with PEC zero boundaries.
module fdtd_field_update
  import fdtd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = FDTD_FRAC_BITS,
  parameter int SIZE_WIDTH = 15
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  input  logic [DATA_WIDTH-1:0] c_self_i,
  input  logic [DATA_WIDTH-1:0] c_curl_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] self_i,
  input  logic [DATA_WIDTH-1:0] nb_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [SIZE_WIDTH-1:0] out_idx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  fdtd_upd_state_e       state_r, state_nxt_s;
  logic                  mode_r;
  logic [SIZE_WIDTH-1:0] size_r, in_cnt_r;
  logic [DATA_WIDTH-1:0] c_self_r, c_curl_r, nb_prev_r, self_hold_r;
  logic                  s1_valid_r, done_r;
  logic [DATA_WIDTH-1:0] s1_self_r;
  logic [DATA_WIDTH:0]   s1_curl_r;
  logic [SIZE_WIDTH-1:0] s1_idx_r;
  logic                  stall_s, accept_s, last_accept_s, drain_done_s, s2_valid_s;
  logic                  issue_s;
  logic [DATA_WIDTH-1:0] issue_self_s;
  logic [DATA_WIDTH:0]   issue_curl_s;
  logic [SIZE_WIDTH-1:0] issue_idx_s;

  assign stall_s       = out_valid_o && !out_ready_i;
  assign in_ready_o    = (state_r == ST_RUN) && !stall_s;
  assign accept_s      = in_valid_i && in_ready_o;
  assign last_accept_s = accept_s && (in_cnt_r == size_r - SIZE_WIDTH'(1));
  assign drain_done_s  = !s1_valid_r && !s2_valid_s && (!out_valid_o || out_ready_i);
  assign busy_o        = (state_r != ST_IDLE);
  assign done_o        = done_r;

  // Tuple issue: Ez issues on each accept; Hy issues element i-1 on the accept
  // of element i, and FLUSH issues the last element against a zero neighbour.
  always_comb begin
    issue_s      = 1'b0;
    issue_self_s = self_i;
    issue_curl_s = $signed({nb_i[DATA_WIDTH-1], nb_i}) - $signed({nb_prev_r[DATA_WIDTH-1], nb_prev_r});
    issue_idx_s  = in_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && (mode_r == FDTD_MODE_EZ)) begin
          issue_s = 1'b1;
        end else if (accept_s && (in_cnt_r != {SIZE_WIDTH{1'b0}})) begin
          issue_s      = 1'b1;
          issue_self_s = self_hold_r;
          issue_idx_s  = in_cnt_r - SIZE_WIDTH'(1);
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        issue_s      = !stall_s;
        issue_self_s = self_hold_r;
        issue_curl_s = {(DATA_WIDTH+1){1'b0}} - {nb_prev_r[DATA_WIDTH-1], nb_prev_r};
        issue_idx_s  = size_r - SIZE_WIDTH'(1);
      end
      default: issue_s = 1'b0;
    endcase
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (size_i == {SIZE_WIDTH{1'b0}}) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_accept_s) begin
          state_nxt_s = (mode_r == FDTD_MODE_HY) ? ST_FLUSH : ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (!stall_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and one-cycle done pulse.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_r == ST_DRAIN) && drain_done_s;
    end
  end

  // Run configuration, input counter, neighbour register and S1 tuple.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mode_r      <= FDTD_MODE_HY;
      size_r      <= {SIZE_WIDTH{1'b0}};
      c_self_r    <= {DATA_WIDTH{1'b0}};
      c_curl_r    <= {DATA_WIDTH{1'b0}};
      in_cnt_r    <= {SIZE_WIDTH{1'b0}};
      nb_prev_r   <= {DATA_WIDTH{1'b0}};
      self_hold_r <= {DATA_WIDTH{1'b0}};
      s1_valid_r  <= 1'b0;
      s1_self_r   <= {DATA_WIDTH{1'b0}};
      s1_curl_r   <= {(DATA_WIDTH+1){1'b0}};
      s1_idx_r    <= {SIZE_WIDTH{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && start_i) begin
        mode_r      <= mode_i;
        size_r      <= size_i;
        c_self_r    <= c_self_i;
        c_curl_r    <= c_curl_i;
        in_cnt_r    <= {SIZE_WIDTH{1'b0}};
        nb_prev_r   <= {DATA_WIDTH{1'b0}};
        self_hold_r <= {DATA_WIDTH{1'b0}};
      end else if (accept_s) begin
        in_cnt_r    <= in_cnt_r + SIZE_WIDTH'(1);
        nb_prev_r   <= nb_i;
        self_hold_r <= self_i;
      end
      if (!stall_s) begin
        s1_valid_r <= issue_s;
        s1_self_r  <= issue_self_s;
        s1_curl_r  <= issue_curl_s;
        s1_idx_r   <= issue_idx_s;
      end
    end
  end

  fdtd_fxp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .TAG_WIDTH  (SIZE_WIDTH)
  ) u_mac (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .en        (!stall_s),
    .in_valid  (s1_valid_r),
    .c_self    (c_self_r),
    .c_curl    (c_curl_r),
    .self_val  (s1_self_r),
    .curl_val  (s1_curl_r),
    .in_tag    (s1_idx_r),
    .s2_valid  (s2_valid_s),
    .out_valid (out_valid_o),
    .out_data  (out_data_o),
    .out_tag   (out_idx_o)
  );

endmodule

// File: tb/tb_fdtd_field_update.sv
// Randomized self-checking bench for fdtd_field_update against a wide-integer
// reference of the update equation with zero boundaries.
module tb_fdtd_field_update;
  import fdtd_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        start_i, mode_i, in_valid_i, out_ready_i;
  logic [14:0] size_i;
  logic [31:0] c_self_i, c_curl_i, self_i, nb_i;
  logic        in_ready_o, out_valid_o, busy_o, done_o;
  logic [31:0] out_data_o;
  logic [14:0] out_idx_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] self_q[$];
  logic [31:0] nb_q[$];

  always #5 ACLK = ~ACLK;

  fdtd_field_update dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start_i(start_i), .mode_i(mode_i),
    .size_i(size_i), .c_self_i(c_self_i), .c_curl_i(c_curl_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .self_i(self_i), .nb_i(nb_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_idx_o(out_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact value of c_self*self + c_curl*curl, floored by 2^16, clamped to 32-bit signed.
  function automatic logic [31:0] model_out(input logic [31:0] cs, input logic [31:0] cc,
                                            input logic [31:0] sv, input longint curl);
    logic signed [71:0] a, b, c, d, acc;
    a = $signed(cs);
    b = $signed(sv);
    c = $signed(cc);
    d = curl;
    acc = (a * b + c * d) >>> 16;
    if (acc > 72'sd2147483647) return 32'h7FFF_FFFF;
    else if (acc < -72'sd2147483648) return 32'h8000_0000;
    else return acc[31:0];
  endfunction

  task automatic do_run(input logic md, input logic [31:0] cs, input logic [31:0] cc,
                        input int stall_len, input bit rnd, input bit spurious, input string tag);
    int n, acc, got, cyc, last_hs, stall_cnt;
    bit done_seen, held, first_seen;
    logic [31:0] hold_data;
    logic [14:0] hold_idx;
    logic [31:0] exp_q[$];
    longint a, b;
    n = self_q.size();
    exp_q = {};
    for (int i = 0; i < n; i++) begin
      if (md == FDTD_MODE_EZ) begin
        a = $signed(nb_q[i]);
        b = 0;
        if (i > 0) b = $signed(nb_q[i-1]);
      end else begin
        a = 0;
        if (i < n - 1) a = $signed(nb_q[i+1]);
        b = $signed(nb_q[i]);
      end
      exp_q.push_back(model_out(cs, cc, self_q[i], a - b));
    end
    @(negedge ACLK);
    start_i = 1'b1; mode_i = md; size_i = 15'(n); c_self_i = cs; c_curl_i = cc;
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    acc = 0; got = 0; last_hs = -10; stall_cnt = 0;
    done_seen = 0; held = 0; first_seen = 0;
    hold_data = 32'h0; hold_idx = 15'h0;
    for (cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
      @(negedge ACLK);
      start_i  = spurious && (cyc == 3);
      mode_i   = 1'($urandom_range(0, 1));
      size_i   = 15'($urandom_range(1, 20));
      c_self_i = $urandom;
      c_curl_i = $urandom;
      if (done_o) begin
        done_seen = 1;
        check_val({tag, "_done_timing"}, 64'(cyc), (n == 0) ? 64'd2 : 64'(last_hs + 1));
        check_val({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
        check_val({tag, "_out_count"}, 64'(got), 64'(n));
      end else begin
        if (stall_cnt > 0) begin
          out_ready_i = 1'b0;
          stall_cnt--;
        end else begin
          out_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        in_valid_i = (acc < n) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        if (acc < n) begin
          self_i = self_q[acc];
          nb_i   = nb_q[acc];
        end else begin
          self_i = $urandom;
          nb_i   = $urandom;
        end
        #1;
        if (cyc == 1) begin
          check_val({tag, "_busy_rise"}, 64'(busy_o), 64'd1);
          check_val({tag, "_ready_first"}, 64'(in_ready_o), 64'(n != 0));
        end
        if (held) begin
          check_val({tag, "_hold_valid"}, 64'(out_valid_o), 64'd1);
          check_val({tag, "_hold_data"}, 64'(out_data_o), 64'(hold_data));
          check_val({tag, "_hold_idx"}, 64'(out_idx_o), 64'(hold_idx));
        end
        if (out_valid_o && !out_ready_i)
          check_val({tag, "_ready_in_stall"}, 64'(in_ready_o), 64'd0);
        if (out_valid_o && !first_seen) begin
          first_seen = 1;
          if (!rnd) check_val({tag, "_latency"}, 64'(cyc), (md == FDTD_MODE_EZ) ? 64'd4 : 64'd5);
        end
        held = out_valid_o && !out_ready_i;
        hold_data = out_data_o;
        hold_idx = out_idx_o;
        if (in_valid_i && in_ready_o) acc++;
        if (out_valid_o && out_ready_i) begin
          if (got < n) begin
            check_val({tag, "_data"}, 64'(out_data_o), 64'(exp_q[got]));
            check_val({tag, "_idx"}, 64'(out_idx_o), 64'(got));
          end else begin
            check_val({tag, "_extra_output"}, 64'd1, 64'd0);
          end
          got++;
          last_hs = cyc;
          if (got == 1) stall_cnt = stall_len;
        end
      end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    if (!done_seen) begin
      check_val({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      @(negedge ACLK);
      check_val({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
    check_val({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
    check_val({tag, "_out_data"}, 64'(out_data_o), 64'd0);
    check_val({tag, "_out_idx"}, 64'(out_idx_o), 64'd0);
    check_val({tag, "_busy"}, 64'(busy_o), 64'd0);
    check_val({tag, "_done"}, 64'(done_o), 64'd0);
  endtask

  task automatic reset_mid_run();
    int acc;
    acc = 0;
    @(negedge ACLK);
    start_i = 1'b1; mode_i = FDTD_MODE_EZ; size_i = 15'd6;
    c_self_i = 32'h0001_0000; c_curl_i = 32'h0000_8000;
    for (int cyc = 0; cyc < 100 && acc < 3; cyc++) begin
      @(negedge ACLK);
      start_i = 1'b0; out_ready_i = 1'b1; in_valid_i = 1'b1;
      self_i = $urandom_range(1, 32'h00FF_FFFF);
      nb_i = $urandom;
      #1;
      if (in_ready_o) acc++;
    end
    check_val("rst_accepts", 64'(acc), 64'd3);
    @(negedge ACLK);
    in_valid_i = 1'b0;
    #1;
    check_val("rst_pre_valid", 64'(out_valid_o), 64'd1);
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      check_val("rst_no_done", 64'(done_o), 64'd0);
    end
  endtask

  initial begin
    ARESETn = 1'b0; start_i = 1'b0; mode_i = 1'b0; size_i = 15'd0;
    c_self_i = 32'h0; c_curl_i = 32'h0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    self_i = 32'h0; nb_i = 32'h0;
    repeat (3) @(negedge ACLK);
    #1;
    check_reset_state("reset");
    ARESETn = 1'b1;

    self_q = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    nb_q   = '{32'h0002_0000, 32'h0004_0000, 32'h0008_0000};
    do_run(FDTD_MODE_EZ, 32'h0001_0000, 32'h0000_8000, 0, 0, 0, "ez3");
    do_run(FDTD_MODE_HY, 32'h0001_0000, 32'h0000_8000, 0, 0, 0, "hy3");

    self_q = '{32'h7FFF_0000};
    nb_q   = '{32'h0000_0000};
    do_run(FDTD_MODE_EZ, 32'h7FFF_0000, 32'h0000_0000, 0, 0, 0, "sat_pos");
    self_q = '{32'h8001_0000};
    do_run(FDTD_MODE_EZ, 32'h7FFF_0000, 32'h0000_0000, 0, 0, 0, "sat_neg");

    self_q = {}; nb_q = {};
    for (int i = 0; i < 8; i++) begin
      self_q.push_back($urandom);
      nb_q.push_back($urandom);
    end
    do_run(FDTD_MODE_HY, $urandom, $urandom, 5, 0, 0, "bp_hy8");

    self_q = {}; nb_q = {};
    do_run(FDTD_MODE_EZ, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, "n0");

    self_q = '{$urandom};
    nb_q   = '{$urandom};
    do_run(FDTD_MODE_HY, $urandom, $urandom, 0, 0, 0, "hy1");

    reset_mid_run();
    self_q = {}; nb_q = {};
    for (int i = 0; i < 6; i++) begin
      self_q.push_back($urandom_range(0, 32'h000F_FFFF));
      nb_q.push_back($urandom_range(0, 32'h000F_FFFF));
    end
    do_run(FDTD_MODE_HY, 32'h0000_C000, 32'hFFFF_4000, 0, 0, 1, "restart");

    for (int r = 0; r < 10; r++) begin
      int n;
      logic [31:0] cs, cc;
      n = $urandom_range(1, 12);
      self_q = {}; nb_q = {};
      for (int i = 0; i < n; i++) begin
        self_q.push_back((r % 2 == 1) ? $urandom : $urandom_range(0, 32'h0003_FFFF) - 32'h0002_0000);
        nb_q.push_back((r % 2 == 1) ? $urandom : $urandom_range(0, 32'h0003_FFFF) - 32'h0002_0000);
      end
      cs = (r < 5) ? $urandom_range(0, 32'h0002_0000) : $urandom;
      cc = (r < 5) ? $urandom_range(0, 32'h0002_0000) - 32'h0001_0000 : $urandom;
      do_run(1'($urandom_range(0, 1)), cs, cc, 0, 1, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
